// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types and helpers for CPU request/ready bus targets
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    INITIALIZE,
    IDLE,
    WAIT,
    ACCESS,
    RESPOND
  } state_t;

  localparam int WORD_BYTES = 4;

  // Byte-lane select: lanes with mask bit set take new_word, others keep old_word.
  function automatic logic [31:0] merge(input logic [3:0]  mask,
                                        input logic [31:0] new_word,
                                        input logic [31:0] old_word);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (mask[b]) result[8*b +: 8] = new_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/bram.sv
// rtl/bram.sv - simple dual-port block RAM, one write port, registered read port
module bram #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 1024,
  parameter int ADDR_LSH = 0,
  localparam int AW      = $clog2(SIZE) + ADDR_LSH
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [SIZE];

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr[AW-1:ADDR_LSH]] <= i_wdata;
    o_rdata <= r_mem[i_raddr[AW-1:ADDR_LSH]];
  end

endmodule

// File: rtl/cpu_bus_mem_responder.sv
// rtl/cpu_bus_mem_responder.sv - request/ready bus RAM target with wait states; stats via CPU_BUS_RESPONDER_STATS_EN
module cpu_bus_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int          SIZE    = 12,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_bus_request,
  input  logic        i_bus_rw,
  input  logic [31:0] i_bus_address,
  input  logic [31:0] i_bus_wdata,
  input  logic [3:0]  i_bus_wmask,
  output logic        o_bus_ready,
  output logic [31:0] o_bus_rdata,
  output logic        o_busy,
  output logic [31:0] o_read_count,
  output logic [31:0] o_write_count
);

  localparam int RANGE = 1 << SIZE;
  localparam logic [3:0] WAIT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t r_state;
  state_t w_next;

  logic [SIZE-1:0] r_clear_idx;
  logic [SIZE-1:0] r_index;
  logic            r_in_window;
  logic            r_rw;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wmask;
  logic [3:0]      r_wait;

  logic [31:0]     w_offset;
  logic            w_in_window;
  logic            w_unused_offset;
  logic            w_ram_we;
  logic [SIZE-1:0] w_ram_waddr;
  logic [31:0]     w_ram_wdata;
  logic [31:0]     w_ram_rdata;
  logic [31:0]     w_old;
  logic [31:0]     w_merged;

  // Wrap-around subtraction makes addresses below BASE land out of window.
  assign w_offset        = i_bus_address - BASE;
  assign w_in_window     = (w_offset[31:SIZE+2] == '0);
  assign w_unused_offset = ^w_offset[1:0];

  assign w_old    = r_in_window ? w_ram_rdata : 32'h0;
  assign w_merged = merge(r_wmask, r_wdata, w_old);

  bram #(
    .WIDTH   (32),
    .SIZE    (RANGE),
    .ADDR_LSH(0)
  ) u_ram (
    .i_clock(i_clock),
    .i_we   (w_ram_we),
    .i_waddr(w_ram_waddr),
    .i_wdata(w_ram_wdata),
    .i_raddr(r_index),
    .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= INITIALIZE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_bus_ready = 1'b0;
    o_bus_rdata = 32'h0;
    o_busy      = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_waddr = r_index;
    w_ram_wdata = w_merged;
    case (r_state)
      INITIALIZE: begin
        o_busy      = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_waddr = r_clear_idx;
        w_ram_wdata = 32'h0;
        if (r_clear_idx == '1) w_next = IDLE;
      end
      IDLE: begin
        if (i_bus_request) w_next = (LATENCY == 0) ? ACCESS : WAIT;
      end
      WAIT: begin
        if (!i_bus_request)          w_next = IDLE;
        else if (r_wait == WAIT_LAST) w_next = ACCESS;
      end
      ACCESS: begin
        w_next = i_bus_request ? RESPOND : IDLE;
      end
      RESPOND: begin
        // A reset landing on the response cycle cancels both the pulse and the write.
        o_bus_ready = !i_reset;
        if (!i_reset) o_bus_rdata = r_rw ? w_merged : w_old;
        w_ram_we    = r_rw && r_in_window && !i_reset;
        w_next      = IDLE;
      end
      default: w_next = INITIALIZE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_clear_idx <= '0;
      r_index     <= '0;
      r_in_window <= 1'b0;
      r_rw        <= 1'b0;
      r_wdata     <= 32'h0;
      r_wmask     <= 4'h0;
      r_wait      <= 4'h0;
    end else begin
      case (r_state)
        INITIALIZE: r_clear_idx <= r_clear_idx + SIZE'(1);
        IDLE: begin
          r_wait <= 4'h0;
          if (i_bus_request) begin
            r_index     <= w_offset[SIZE+1:2];
            r_in_window <= w_in_window;
            r_rw        <= i_bus_rw;
            r_wdata     <= i_bus_wdata;
            r_wmask     <= i_bus_wmask;
          end
        end
        WAIT:    r_wait <= r_wait + 4'd1;
        default: ;
      endcase
    end
  end

`ifdef CPU_BUS_RESPONDER_STATS_EN
  logic [31:0] r_read_count;
  logic [31:0] r_write_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_read_count  <= 32'h0;
      r_write_count <= 32'h0;
    end else if (r_state == RESPOND) begin
      if (r_rw) r_write_count <= r_write_count + 32'd1;
      else      r_read_count  <= r_read_count + 32'd1;
    end
  end

  assign o_read_count  = r_read_count;
  assign o_write_count = r_write_count;
`else
  assign o_read_count  = 32'h0;
  assign o_write_count = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_bus_mem_responder.sv
// tb/tb_cpu_bus_mem_responder.sv - directed and randomized checks against a word-array memory model
module tb_cpu_bus_mem_responder;

  localparam int SIZE  = 12;
  localparam int LAT   = 2;
  localparam int RANGE = 1 << SIZE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  mask = 4'h0;
  logic        ready;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] rcount;
  logic [31:0] wcount;

  always #5 clk = ~clk;

  cpu_bus_mem_responder #(.SIZE(SIZE), .LATENCY(LAT), .BASE(32'h0)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_bus_request(req),
    .i_bus_rw     (rw),
    .i_bus_address(addr),
    .i_bus_wdata  (wdata),
    .i_bus_wmask  (mask),
    .o_bus_ready  (ready),
    .o_bus_rdata  (rdata),
    .o_busy       (busy),
    .o_read_count (rcount),
    .o_write_count(wcount)
  );

  logic [31:0] mem [RANGE];
  int          exp_reads;
  int          exp_writes;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < RANGE; i++) mem[i] = 32'h0;
    exp_reads  = 0;
    exp_writes = 0;
  endtask

  task automatic count_init();
    int n;
    n = 0;
    while (busy && n < 10000) begin
      n++;
      step();
    end
    chk("init_busy_cycles", 32'(n), 32'(RANGE));
    model_clear();
  endtask

  task automatic run_txn(input string tag, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         output logic [31:0] got);
    int          lat;
    logic [31:0] idx;
    bit          inw;
    logic [31:0] old;
    logic [31:0] bm;
    logic [31:0] exp;
    req = 1'b1; rw = w; addr = a; wdata = d; mask = m;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!ready && lat < 40);
    got = rdata;
    req = 1'b0;
    idx = a >> 2;
    inw = idx < RANGE;
    old = inw ? mem[idx[SIZE-1:0]] : 32'h0;
    bm  = 32'h0;
    for (int b = 0; b < 4; b++) if (m[b]) bm[8*b +: 8] = 8'hFF;
    exp = w ? ((d & bm) | (old & ~bm)) : old;
    if (w && inw) mem[idx[SIZE-1:0]] = exp;
    if (w) exp_writes++; else exp_reads++;
    chk({tag, "_latency"}, 32'(lat), 32'(2 + LAT));
    if (!(w && !inw)) chk({tag, "_rdata"}, got, exp);
    step();
    chk({tag, "_ready_single"}, {31'h0, ready}, 32'h0);
  endtask

  task automatic check_counts(input string tag);
`ifdef CPU_BUS_RESPONDER_STATS_EN
    chk({tag, "_reads"}, rcount, 32'(exp_reads));
    chk({tag, "_writes"}, wcount, 32'(exp_writes));
`else
    chk({tag, "_reads"}, rcount, 32'h0);
    chk({tag, "_writes"}, wcount, 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] w0, w1, w2;
    int          cyc;
    int          hits;
    int          k;
    int          ready_at [3];

    step();
    step();
    chk("reset_busy", {31'h0, busy}, 32'h1);
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rcount", rcount, 32'h0);
    chk("reset_wcount", wcount, 32'h0);
    rst = 1'b0;
    count_init();

    run_txn("read_0x10", 1'b0, 32'h10, 32'h0, 4'h0, got);
    run_txn("write_0x20", 1'b1, 32'h20, 32'hCAFE_BABE, 4'hF, got);
    run_txn("read_0x20", 1'b0, 32'h20, 32'h0, 4'h0, got);
    chk("read_0x20_const", got, 32'hCAFE_BABE);
    run_txn("write_0x0_m5", 1'b1, 32'h0, 32'hCAFE_BABE, 4'b0101, got);
    run_txn("read_0x0", 1'b0, 32'h0, 32'h0, 4'h0, got);
    chk("read_0x0_const", got, 32'h00FE_00BE);
    run_txn("write_mask0", 1'b1, 32'h20, 32'h1234_5678, 4'h0, got);
    run_txn("read_mask0", 1'b0, 32'h20, 32'h0, 4'h0, got);
    chk("read_mask0_const", got, 32'hCAFE_BABE);

    run_txn("read_oow", 1'b0, 32'h4000, 32'h0, 4'h0, got);
    chk("read_oow_const", got, 32'h0);
    run_txn("write_oow", 1'b1, 32'h4000, 32'hFFFF_FFFF, 4'hF, got);
    run_txn("read_0x0_after_oow", 1'b0, 32'h0, 32'h0, 4'h0, got);
    chk("oow_no_alias", got, 32'h00FE_00BE);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) a = 32'h4000 + ($urandom_range(0, 255) << 2);
      else a = $urandom_range(0, 31) << 2;
      run_txn("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), got);
    end
    check_counts("counts_rand");

    w0 = $urandom; w1 = $urandom; w2 = $urandom | 32'h1;
    run_txn("pre_w0", 1'b1, 32'h0, w0, 4'hF, got);
    run_txn("pre_w1", 1'b1, 32'h4, w1, 4'hF, got);
    run_txn("pre_w2", 1'b1, 32'h8, w2, 4'hF, got);

    req = 1'b1; rw = 1'b0; addr = 32'h0;
    cyc = 0; hits = 0; k = 0;
    while (cyc < 20) begin
      step();
      cyc++;
      if (ready) begin
        hits++;
        if (k < 3) begin
          ready_at[k] = cyc;
          chk("b2b_rdata", rdata, mem[k]);
        end
        k++;
        if (k >= 3) req = 1'b0;
        else addr = 32'(4 * k);
      end
    end
    exp_reads += 3;
    chk("b2b_pulses", 32'(hits), 32'd3);
    chk("b2b_first", 32'(ready_at[0]), 32'(2 + LAT));
    chk("b2b_gap1", 32'(ready_at[1] - ready_at[0]), 32'(3 + LAT));
    chk("b2b_gap2", 32'(ready_at[2] - ready_at[1]), 32'(3 + LAT));

    req = 1'b1; rw = 1'b0; addr = 32'h10;
    step(); step();
    req = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin step(); if (ready) hits++; end
    chk("abort_read_no_ready", 32'(hits), 32'd0);
    req = 1'b1; rw = 1'b1; addr = 32'h10; wdata = 32'hFFFF_FFFF; mask = 4'hF;
    hits = 0;
    for (int i = 0; i < 3; i++) begin step(); if (ready) hits++; end
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); if (ready) hits++; end
    chk("abort_write_no_ready", 32'(hits), 32'd0);
    run_txn("read_after_abort", 1'b0, 32'h10, 32'h0, 4'h0, got);
    check_counts("counts_pre_reset");

    req = 1'b1; rw = 1'b1; addr = 32'h8; wdata = 32'hDEAD_BEEF; mask = 4'hF;
    step();
    hits = 0;
    rst = 1'b1;
    step();
    if (ready) hits++;
    req = 1'b0;
    step();
    if (ready) hits++;
    chk("reset_wait_busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    chk("reset_wait_no_ready", 32'(hits), 32'd0);
    count_init();
    run_txn("read_0x8_after_reinit", 1'b0, 32'h8, 32'h0, 4'h0, got);
    chk("read_0x8_zero", got, 32'h0);

    run_txn("stat_r2", 1'b0, 32'h4, 32'h0, 4'h0, got);
    run_txn("stat_w1", 1'b1, 32'h4, 32'hA5A5_5A5A, 4'hF, got);
    run_txn("stat_r3", 1'b0, 32'h4, 32'h0, 4'h0, got);
    run_txn("stat_w2", 1'b1, 32'hC, 32'h0BAD_F00D, 4'b1100, got);
    chk("stat_model_reads", 32'(exp_reads), 32'd3);
    check_counts("counts_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_mem_responder.md
Name: cpu_bus_mem_responder

Overview:
- Bus target (responder) for the CPU fetch/data request/ready bus; answers an initiator such as the instruction cache.
- Backs a word-addressed on-chip RAM with configurable wait states and byte-masked writes.
- Zero-clears its memory after reset and withholds ready until clearing completes.
- Used as boot/scratch RAM and as the simulation memory model behind the caches.

Parameters:
- SIZE, 12, log2 of word count (RANGE = 1 << SIZE words of 32 bits).
- LATENCY, 2, extra wait cycles inserted before ready, 0..15.
- BASE, 32'h0000_0000, byte base address of the window.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_bus_request  in  1  initiator holds high until it sees ready.
- i_bus_rw  in  1  1 = write, 0 = read.
- i_bus_address  in  32  byte address; bits [1:0] ignored.
- i_bus_wdata  in  32  write data.
- i_bus_wmask  in  4  byte enables; bit n covers wdata[8n+7:8n].
- o_bus_ready  out  1  single-cycle completion pulse.
- o_bus_rdata  out  32  read data, valid only while ready = 1.
- o_busy  out  1  high while clearing memory.
- o_read_count  out  32  completed reads (stats feature).
- o_write_count  out  32  completed writes (stats feature).

Behaviour:
- Reset values: o_bus_ready = 0, o_bus_rdata = 0, o_busy = 1, counters = 0; state = INITIALIZE; clear index = 0.
- Reset at any point, including mid-transaction: the transaction is dropped, no ready is issued, no write is committed (unless the reset cycle itself is RESPOND, in which case the write is also suppressed), and the block enters INITIALIZE.
- INITIALIZE:
  - Writes 0 to word index 0..RANGE-1, one word per cycle.
  - Moves to IDLE after the last write; total duration RANGE cycles.
  - o_busy = 1 throughout; requests are ignored but not lost, because the initiator keeps them held.
- IDLE:
  - If i_bus_request = 1, latch address, rw, wdata and wmask, then go to WAIT, or to ACCESS when LATENCY = 0.
- WAIT: counts LATENCY cycles, then goes to ACCESS.
- ACCESS: presents the latched index to the RAM read port (one-cycle read latency); goes to RESPOND.
- RESPOND:
  - o_bus_ready = 1.
  - Read: o_bus_rdata = RAM word.
  - Write: merged = per-byte select(wmask, wdata, RAM word); merged is written this cycle; o_bus_rdata = merged.
  - Always returns to IDLE.
- Latency: request first seen high in cycle T gives ready in cycle T + 2 + LATENCY.
- Back-to-back: a request still high in the cycle after ready is a new transaction, sampled in IDLE. Minimum request-to-request period is 3 + LATENCY cycles.
- Request dropped in WAIT/ACCESS (protocol violation): abort to IDLE, no ready, no write.
- Address decode: index = (addr - BASE) >> 2, computed modulo 2^32 before the range check.
  - Index >= RANGE (out of window): the transaction completes with normal timing.
  - Out-of-window read data = 32'h0; out-of-window writes are discarded.
- Write with wmask = 4'b0000: completes normally, memory unchanged.
- o_bus_rdata = 0 whenever ready = 0.

Optional Feature:
- Macro: CPU_BUS_RESPONDER_STATS_EN.
- Defined:
  - o_read_count / o_write_count increment on each RESPOND cycle, by transaction type, including out-of-window accesses.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - state enum: INITIALIZE, IDLE, WAIT, ACCESS, RESPOND.
  - WORD_BYTES = 4.
  - byte-merge function merge(mask, new, old), also used by future data-cache write paths.
- RAM is the existing BRAM module (WIDTH 32, SIZE RANGE, ADDR_LSH 0); no new sub-module.
- Wait counter and merge logic stay inline.

Test Plan:
- Reset, then count cycles: o_busy high for exactly 4096 cycles (SIZE = 12). Read of 0x0000_0010 returns 0, with ready exactly at T + 4 (LATENCY = 2).
- Write 0x0000_0020 = 0xCAFE_BABE with mask 4'b1111, then read it back → 0xCAFE_BABE. Then write 0x0000_0000 with mask 4'b0101 → read gives 0x00FE_00BE.
- Initiator modelled on the instruction cache issues back-to-back reads 0x0, 0x4, 0x8 with the request held continuously → three single-cycle ready pulses 5 cycles apart, with correct data each.
- Read 0x0000_4000 (out of window) → ready at T + 4 with rdata 0. Write to 0x0000_4000 leaves word 0 unchanged.
- Assert reset during WAIT of a write to 0x8 → no ready. After re-initialization, a read of 0x8 returns 0 and o_busy re-asserts for 4096 cycles.
- With CPU_BUS_RESPONDER_STATS_EN defined: 3 reads + 2 writes → o_read_count = 3, o_write_count = 2. Without the macro, both stay 0.
